// File: rtl/addsub_serial.sv
// addsub_serial - digit-serial adder/subtractor with start/done handshake.
//
// Processes DIGIT bits of the WIDTH-bit operands per clock, so one operation
// takes N = WIDTH/DIGIT RUN cycles followed by a single DONE cycle.
// Subtraction is done as a + ~b + 1: the B operand is inverted on load and
// the first carry-in is the sub flag.
//
// Ports:
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset
//   start    operation request, sampled only while busy = 0
//   sub      0 = a + b, 1 = a - b (sampled with start)
//   a, b     WIDTH-bit operands (sampled with start)
//   busy     operation in progress
//   done     one-cycle completion pulse; result/flags valid from this cycle
//   result   sum/difference modulo 2^WIDTH, held until the next completion
//   carry    carry-out for add, borrow (a < b unsigned) for sub
//   overflow two's-complement signed overflow
//   zero     result == 0
module addsub_serial #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             overflow,
    output logic             zero
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t state_r;
    state_t state_n_s;
    logic   load_s;
    logic   step_s;
    logic   last_s;

    logic [WIDTH-1:0] a_sh_r;
    logic [WIDTH-1:0] b_sh_r;
    logic [WIDTH-1:0] res_sh_r;
    logic [CW-1:0]    cnt_r;
    logic             cin_r;
    logic             sub_r;
    logic             sa_r;
    logic             sb_r;

    logic [WIDTH-1:0]       b_inv_s;
    logic [DIGIT:0]         dsum_s;
    logic [WIDTH+DIGIT-1:0] a_cat_s;
    logic [WIDTH+DIGIT-1:0] b_cat_s;
    logic [WIDTH+DIGIT-1:0] res_cat_s;
    logic [WIDTH-1:0]       a_next_s;
    logic [WIDTH-1:0]       b_next_s;
    logic [WIDTH-1:0]       res_next_s;

    logic             busy_r;
    logic             done_r;
    logic [WIDTH-1:0] result_r;
    logic             carry_r;
    logic             overflow_r;
    logic             zero_r;

    // Digit adder and the shifted register images for the next RUN cycle.
    // The concatenations keep the shifts legal when DIGIT == WIDTH.
    always_comb begin
        b_inv_s    = b ^ {WIDTH{sub}};
        dsum_s     = {1'b0, a_sh_r[DIGIT-1:0]} + {1'b0, b_sh_r[DIGIT-1:0]}
                   + {{DIGIT{1'b0}}, cin_r};
        a_cat_s    = {{DIGIT{1'b0}}, a_sh_r};
        b_cat_s    = {{DIGIT{1'b0}}, b_sh_r};
        res_cat_s  = {dsum_s[DIGIT-1:0], res_sh_r};
        a_next_s   = a_cat_s[WIDTH+DIGIT-1:DIGIT];
        b_next_s   = b_cat_s[WIDTH+DIGIT-1:DIGIT];
        res_next_s = res_cat_s[WIDTH+DIGIT-1:DIGIT];
        last_s     = (cnt_r == LAST);
    end

    // Next-state logic: IDLE and DONE both accept start, RUN ignores it.
    always_comb begin
        state_n_s = state_r;
        load_s    = 1'b0;
        step_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    load_s    = 1'b1;
                    state_n_s = RUN;
                end else begin
                    state_n_s = IDLE;
                end
            end
            RUN: begin
                step_s = 1'b1;
                if (last_s) begin
                    state_n_s = DONE;
                end else begin
                    state_n_s = RUN;
                end
            end
            DONE: begin
                if (start) begin
                    load_s    = 1'b1;
                    state_n_s = RUN;
                end else begin
                    state_n_s = IDLE;
                end
            end
            default: begin
                state_n_s = IDLE;
            end
        endcase
    end

    // State register plus registered busy/done decoded from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_n_s;
            busy_r  <= (state_n_s == RUN);
            done_r  <= (state_n_s == DONE);
        end
    end

    // Operand/result shift registers, carry chain and digit counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh_r   <= {WIDTH{1'b0}};
            b_sh_r   <= {WIDTH{1'b0}};
            res_sh_r <= {WIDTH{1'b0}};
            cnt_r    <= {CW{1'b0}};
            cin_r    <= 1'b0;
            sub_r    <= 1'b0;
            sa_r     <= 1'b0;
            sb_r     <= 1'b0;
        end else if (load_s) begin
            a_sh_r <= a;
            b_sh_r <= b_inv_s;
            cnt_r  <= {CW{1'b0}};
            cin_r  <= sub;
            sub_r  <= sub;
            sa_r   <= a[WIDTH-1];
            sb_r   <= b_inv_s[WIDTH-1];
        end else if (step_s) begin
            a_sh_r   <= a_next_s;
            b_sh_r   <= b_next_s;
            res_sh_r <= res_next_s;
            cnt_r    <= cnt_r + CW'(1);
            cin_r    <= dsum_s[DIGIT];
        end
    end

    // Visible result and flags load only on the edge that enters DONE.
    // Overflow: operands (after inversion) agree in sign, result does not.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_r   <= {WIDTH{1'b0}};
            carry_r    <= 1'b0;
            overflow_r <= 1'b0;
            zero_r     <= 1'b0;
        end else if (step_s && last_s) begin
            result_r   <= res_next_s;
            carry_r    <= dsum_s[DIGIT] ^ sub_r;
            overflow_r <= (sa_r == sb_r) && (res_next_s[WIDTH-1] != sa_r);
            zero_r     <= (res_next_s == {WIDTH{1'b0}});
        end
    end

    assign busy     = busy_r;
    assign done     = done_r;
    assign result   = result_r;
    assign carry    = carry_r;
    assign overflow = overflow_r;
    assign zero     = zero_r;

endmodule

// File: tb/tb_addsub_serial.sv
// Testbench for addsub_serial: six configurations share one set of inputs.
// Instance 2 (WIDTH=16, DIGIT=4) is used for the directed handshake steps;
// all instances are compared against an arithmetic reference model.
module tb_addsub_serial;

    localparam int NI = 6;
    localparam int WS [NI] = '{16, 16, 16, 16, 16, 8};
    localparam int DS [NI] = '{1, 2, 4, 8, 16, 4};
    localparam int REF = 2;

    bit          clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        sub;
    logic [15:0] a_in;
    logic [15:0] b_in;
    int          cyc = 0;

    logic        busy_w  [NI];
    logic        done_w  [NI];
    logic        carry_w [NI];
    logic        ovf_w   [NI];
    logic        zero_w  [NI];
    logic [15:0] res_w   [NI];
    int          nd_w    [NI];
    int          dc_w    [NI];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Edge counter: after edge k, cyc == k.
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
        localparam int W = WS[gi];
        localparam int D = DS[gi];
        logic         busy_l, done_l, carry_l, ovf_l, zero_l;
        logic [W-1:0] res_l;
        int           nd_l = 0;
        int           dc_l = 0;

        addsub_serial #(.WIDTH(W), .DIGIT(D)) u_dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .start    (start),
            .sub      (sub),
            .a        (a_in[W-1:0]),
            .b        (b_in[W-1:0]),
            .busy     (busy_l),
            .done     (done_l),
            .result   (res_l),
            .carry    (carry_l),
            .overflow (ovf_l),
            .zero     (zero_l)
        );

        // Count done pulses and remember the edge that produced the last one.
        always @(negedge clk) begin
            if (done_l) begin
                nd_l <= nd_l + 1;
                dc_l <= cyc;
            end
        end

        assign busy_w[gi]  = busy_l;
        assign done_w[gi]  = done_l;
        assign carry_w[gi] = carry_l;
        assign ovf_w[gi]   = ovf_l;
        assign zero_w[gi]  = zero_l;
        assign res_w[gi]   = 16'(res_l);
        assign nd_w[gi]    = nd_l;
        assign dc_w[gi]    = dc_l;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain integer arithmetic on w-bit operands.
    task automatic model(input int w, input logic [15:0] av, input logic [15:0] bv,
                         input logic s, output logic [15:0] r, output logic c,
                         output logic o, output logic z);
        longint m, ai, bi, full, sa, sb, sres, half;
        m    = (64'sd1 <<< w) - 1;
        half = 64'sd1 <<< (w - 1);
        ai   = longint'(av) & m;
        bi   = longint'(bv) & m;
        if (s) begin
            full = ai - bi;
            c    = (ai < bi);
        end else begin
            full = ai + bi;
            c    = (full > m);
        end
        r    = 16'(full & m);
        sa   = (ai >= half) ? ai - (m + 1) : ai;
        sb   = (bi >= half) ? bi - (m + 1) : bi;
        sres = s ? (sa - sb) : (sa + sb);
        o    = (sres > half - 1) || (sres < -half);
        z    = ((full & m) == 0);
    endtask

    // One operation on all instances; compare every instance with the model.
    task automatic run_op(input logic [15:0] av, input logic [15:0] bv, input logic s);
        int          snap [NI];
        int          e0;
        bit          all_done;
        logic [15:0] r;
        logic        c, o, z;
        for (int i = 0; i < NI; i++) snap[i] = nd_w[i];
        a_in  = av;
        b_in  = bv;
        sub   = s;
        start = 1'b1;
        e0    = cyc + 1;
        step();
        start = 1'b0;
        all_done = 1'b0;
        for (int k = 0; k < 40 && !all_done; k++) begin
            all_done = 1'b1;
            for (int i = 0; i < NI; i++) if (nd_w[i] == snap[i]) all_done = 1'b0;
            if (!all_done) step();
        end
        chk("op_timeout", 32'(all_done), 32'd1);
        for (int i = 0; i < NI; i++) begin
            model(WS[i], av, bv, s, r, c, o, z);
            chk($sformatf("done_count[%0d]", i), 32'(nd_w[i] - snap[i]), 32'd1);
            chk($sformatf("latency[%0d]", i), 32'(dc_w[i] - e0 + 1), 32'(WS[i] / DS[i] + 1));
            chk($sformatf("result[%0d] a=%h b=%h s=%b", i, av, bv, s), 32'(res_w[i]), 32'(r));
            chk($sformatf("carry[%0d]", i), 32'(carry_w[i]), 32'(c));
            chk($sformatf("overflow[%0d]", i), 32'(ovf_w[i]), 32'(o));
            chk($sformatf("zero[%0d]", i), 32'(zero_w[i]), 32'(z));
        end
        step();
    endtask

    initial begin
        logic [15:0] r1, r2;
        logic        c, o, z;
        int          snap;

        rst_n = 1'b0;
        start = 1'b0;
        sub   = 1'b0;
        a_in  = 16'h0000;
        b_in  = 16'h0000;
        repeat (3) step();
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("rst_busy[%0d]", i), 32'(busy_w[i]), 32'd0);
            chk($sformatf("rst_done[%0d]", i), 32'(done_w[i]), 32'd0);
            chk($sformatf("rst_result[%0d]", i), 32'(res_w[i]), 32'd0);
            chk($sformatf("rst_flags[%0d]", i), {29'd0, carry_w[i], ovf_w[i], zero_w[i]}, 32'd0);
        end
        rst_n = 1'b1;
        step();

        // Directed add with cycle-by-cycle busy/done on the 16/4 instance.
        a_in = 16'h1234; b_in = 16'h0FFF; sub = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("add_busy", 32'(busy_w[REF]), 32'd1);
            chk("add_done_low", 32'(done_w[REF]), 32'd0);
            if (k < 3) step();
        end
        step();
        chk("add_done", 32'(done_w[REF]), 32'd1);
        chk("add_busy_low", 32'(busy_w[REF]), 32'd0);
        chk("add_result", 32'(res_w[REF]), 32'h2233);
        chk("add_flags", {29'd0, carry_w[REF], ovf_w[REF], zero_w[REF]}, 32'd0);
        step();
        chk("add_done_pulse", 32'(done_w[REF]), 32'd0);
        repeat (20) step();

        // start held high with changing operands during RUN.
        snap = nd_w[REF];
        a_in = 16'h4000; b_in = 16'h1111; sub = 1'b1; start = 1'b1;
        model(16, a_in, b_in, 1'b1, r1, c, o, z);
        for (int k = 0; k < 4; k++) begin
            step();
            a_in = 16'($urandom);
            b_in = 16'($urandom);
            sub  = 1'($urandom_range(0, 1));
        end
        start = 1'b0;
        step();
        chk("hold_done", 32'(done_w[REF]), 32'd1);
        chk("hold_result", 32'(res_w[REF]), 32'(r1));
        repeat (10) step();
        chk("hold_one_done", 32'(nd_w[REF] - snap), 32'd1);
        repeat (20) step();

        // Back-to-back: second start issued in the done cycle.
        a_in = 16'h0100; b_in = 16'h0023; sub = 1'b0; start = 1'b1;
        model(16, a_in, b_in, 1'b0, r1, c, o, z);
        step();
        start = 1'b0;
        repeat (4) step();
        chk("b2b_done1", 32'(done_w[REF]), 32'd1);
        chk("b2b_result1", 32'(res_w[REF]), 32'(r1));
        a_in = 16'h8000; b_in = 16'h0001; sub = 1'b1; start = 1'b1;
        model(16, a_in, b_in, 1'b1, r2, c, o, z);
        for (int k = 0; k < 4; k++) begin
            step();
            start = 1'b0;
            a_in  = 16'hFFFF;
            chk("b2b_busy2", 32'(busy_w[REF]), 32'd1);
            chk("b2b_hold_result", 32'(res_w[REF]), 32'(r1));
            chk("b2b_no_done", 32'(done_w[REF]), 32'd0);
        end
        step();
        chk("b2b_done2", 32'(done_w[REF]), 32'd1);
        chk("b2b_result2", 32'(res_w[REF]), 32'(r2));
        chk("b2b_ovf2", 32'(ovf_w[REF]), 32'(o));

        // Asynchronous reset in the middle of a run.
        a_in = 16'h1357; b_in = 16'h2468; sub = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        rst_n = 1'b0;
        #1;
        chk("mrst_busy", 32'(busy_w[REF]), 32'd0);
        chk("mrst_done", 32'(done_w[REF]), 32'd0);
        chk("mrst_result", 32'(res_w[REF]), 32'd0);
        chk("mrst_flags", {29'd0, carry_w[REF], ovf_w[REF], zero_w[REF]}, 32'd0);
        step();
        rst_n = 1'b1;
        snap = nd_w[REF];
        repeat (10) step();
        chk("mrst_no_done", 32'(nd_w[REF] - snap), 32'd0);

        // Boundary vectors on every configuration.
        run_op(16'h1234, 16'h0FFF, 1'b0);
        run_op(16'hFFFF, 16'h0001, 1'b0);
        run_op(16'h7FFF, 16'h0001, 1'b0);
        run_op(16'h0005, 16'h0007, 1'b1);
        run_op(16'h8000, 16'h0001, 1'b1);
        run_op(16'h00A5, 16'h00A5, 1'b1);
        run_op(16'h0000, 16'h0000, 1'b0);
        run_op(16'h0080, 16'h007F, 1'b1);

        // Random sweep.
        for (int n = 0; n < 400; n++) begin
            run_op(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
